// File: rtl/add_seq_ctrl.sv
// add_seq_ctrl: sequential W = N*K bit adder/subtractor.
// One N-bit adder slice is reused over K cycles, least-significant slice first.
// The carry between slices is held in a register.
// Requests arrive on a valid/ready command port; results leave on a valid/ready result port.
// Optional macro ADD_SEQ_EARLY_EXIT_EN lets an add finish early. It applies when the
// remaining operand bits are zero and no carry is pending.
module add_seq_ctrl #(
    parameter int unsigned N = 4,
    parameter int unsigned K = 4
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start_valid,
    output logic           start_ready,
    input  logic [N*K-1:0] a,
    input  logic [N*K-1:0] b,
    input  logic           cin,
    input  logic           op,
    output logic           res_valid,
    input  logic           res_ready,
    output logic [N*K-1:0] sum,
    output logic           cout,
    output logic           ovf
);

    localparam int unsigned W    = N * K;
    localparam int unsigned CntW = (K > 1) ? $clog2(K) : 1;
    localparam logic [CntW-1:0] LastCnt = CntW'(K - 1);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e          state_q, state_d;
    logic [W-1:0]    a_q, a_d, b_q, b_d, sum_q, sum_d;
    logic            carry_q, carry_d, cout_q, cout_d, ovf_q, ovf_d;
    logic [CntW-1:0] cnt_q, cnt_d;

    logic            accept;
    logic            last_slice;
    logic [N-1:0]    slice_a, slice_b, slice_sum;
    logic            slice_co;
    logic            early_exit;

    assign accept     = (state_q == StIdle) && start_valid;
    assign last_slice = (cnt_q == LastCnt);

    // Shared N-bit slice adder fed by the current slice of A, B' and the carry register
    always_comb begin
        slice_a = a_q[N*cnt_q +: N];
        slice_b = b_q[N*cnt_q +: N];
        {slice_co, slice_sum} = {1'b0, slice_a} + {1'b0, slice_b} + {{N{1'b0}}, carry_q};
    end

`ifdef ADD_SEQ_EARLY_EXIT_EN
    logic op_q, op_d;
    logic upper_zero;

    // Remember the operation kind; early exit is only legal for add
    always_comb begin
        op_d = accept ? op : op_q;
    end

    // Operation kind register
    always_ff @(posedge clk) begin
        if (rst) begin
            op_q <= 1'b0;
        end else begin
            op_q <= op_d;
        end
    end

    // Exit early when nothing above this slice can change the result
    always_comb begin
        upper_zero = (((a_q | b_q) >> (N * (32'(cnt_q) + 32'd1))) == '0);
        early_exit = (state_q == StRun) && !op_q && !slice_co && upper_zero && !last_slice;
    end
`else
    assign early_exit = 1'b0;
`endif

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: if (start_valid) state_d = StRun;
            StRun:  if (last_slice || early_exit) state_d = StDone;
            StDone: if (res_ready) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Datapath next state: capture on accept, one slice per RUN cycle, hold otherwise
    always_comb begin
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        carry_d = carry_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        cnt_d   = cnt_q;
        if (accept) begin
            a_d     = a;
            b_d     = op ? ~b : b;
            carry_d = op | cin;
            cnt_d   = '0;
            sum_d   = '0;
            cout_d  = 1'b0;
            ovf_d   = 1'b0;
        end else if (state_q == StRun) begin
            sum_d[N*cnt_q +: N] = slice_sum;
            carry_d             = slice_co;
            // Return to zero after the last slice so the counter stays within 0..K-1
            cnt_d               = last_slice ? '0 : cnt_q + CntW'(1);
            if (last_slice) begin
                cout_d = slice_co;
                ovf_d  = (a_q[W-1] == b_q[W-1]) && (slice_sum[N-1] != a_q[W-1]);
            end else if (early_exit) begin
                cout_d = 1'b0;
                ovf_d  = 1'b0;
                cnt_d  = '0;
            end
        end
    end

    // Datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
            cnt_q   <= cnt_d;
        end
    end

    // Outputs are pure decodes of registered state
    always_comb begin
        start_ready = (state_q == StIdle);
        res_valid   = (state_q == StDone);
        sum         = sum_q;
        cout        = cout_q;
        ovf         = ovf_q;
    end

endmodule

// File: tb/tb_add_seq_ctrl.sv
// Self-checking bench for add_seq_ctrl (N=4, K=4).
// Uses directed vectors followed by randomized operations compared against an arithmetic model.
module tb_add_seq_ctrl;

    localparam int unsigned N = 4;
    localparam int unsigned K = 4;
    localparam int unsigned W = N * K;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start_valid = 1'b0;
    logic         start_ready;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         cin = 1'b0;
    logic         op = 1'b0;
    logic         res_valid;
    logic         res_ready = 1'b0;
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    add_seq_ctrl #(.N(N), .K(K)) dut (
        .clk         (clk),
        .rst         (rst),
        .start_valid (start_valid),
        .start_ready (start_ready),
        .a           (a),
        .b           (b),
        .cin         (cin),
        .op          (op),
        .res_valid   (res_valid),
        .res_ready   (res_ready),
        .sum         (sum),
        .cout        (cout),
        .ovf         (ovf)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference: plain W-bit arithmetic plus the early-exit latency rule
    task automatic ref_op(input logic [W-1:0] ra, input logic [W-1:0] rb, input logic rcin,
                          input logic rop, output logic [W-1:0] s, output logic co,
                          output logic v, output int lat);
        logic [W:0] full;
        if (rop) begin
            s  = ra - rb;
            co = (ra >= rb);
            v  = (ra[W-1] != rb[W-1]) && (s[W-1] != ra[W-1]);
        end else begin
            full = {1'b0, ra} + {1'b0, rb} + {{W{1'b0}}, rcin};
            s    = full[W-1:0];
            co   = full[W];
            v    = (ra[W-1] == rb[W-1]) && (s[W-1] != ra[W-1]);
        end
        lat = K;
`ifdef ADD_SEQ_EARLY_EXIT_EN
        if (!rop) begin
            for (int c = 0; c < int'(K) - 1; c++) begin
                int  bits;
                int  lo;
                bits = (c + 1) * int'(N);
                lo   = (int'(ra) % (1 << bits)) + (int'(rb) % (1 << bits)) + int'(rcin);
                if (lo < (1 << bits) && (int'(ra) >> bits) == 0 && (int'(rb) >> bits) == 0) begin
                    lat = c + 1;
                    break;
                end
            end
        end
`endif
    endtask

    // Issue one op, measure latency, check result, apply hold cycles of backpressure, hand off
    task automatic do_op(input string tag, input logic [W-1:0] oa, input logic [W-1:0] ob,
                         input logic ocin, input logic oop, input int hold);
        logic [W-1:0] es;
        logic         eco, ev;
        int           elat, lat, guard;
        ref_op(oa, ob, ocin, oop, es, eco, ev, elat);
        @(negedge clk);
        guard = 0;
        while (!start_ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        check_eq({tag, ".start_ready"}, 32'(start_ready), 32'd1);
        a = oa; b = ob; cin = ocin; op = oop; start_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start_valid = 1'b0;
        a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
        lat = 0;
        while (!res_valid && lat < 2 * int'(K) + 4) begin
            check_eq({tag, ".busy"}, 32'(start_ready), 32'd0);
            @(posedge clk);
            @(negedge clk);
            lat++;
        end
        check_eq({tag, ".latency"}, 32'(lat), 32'(elat));
        check_eq({tag, ".sum"}, 32'(sum), 32'(es));
        check_eq({tag, ".cout"}, 32'(cout), 32'(eco));
        check_eq({tag, ".ovf"}, 32'(ovf), 32'(ev));
        for (int i = 0; i < hold; i++) begin
            start_valid = 1'($urandom);
            @(posedge clk);
            @(negedge clk);
            check_eq({tag, ".bp_valid"}, 32'(res_valid), 32'd1);
            check_eq({tag, ".bp_ready"}, 32'(start_ready), 32'd0);
            check_eq({tag, ".bp_res"}, {15'd0, ovf, cout, sum}, {15'd0, ev, eco, es});
        end
        start_valid = 1'b0;
        res_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        res_ready = 1'b0;
        check_eq({tag, ".handoff_valid"}, 32'(res_valid), 32'd0);
        check_eq({tag, ".handoff_ready"}, 32'(start_ready), 32'd1);
        check_eq({tag, ".held_sum"}, 32'(sum), 32'(es));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned sel;
        logic [W-1:0] mask;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check_eq("reset.start_ready", 32'(start_ready), 32'd1);
        check_eq("reset.res_valid", 32'(res_valid), 32'd0);
        check_eq("reset.sum", 32'(sum), 32'd0);
        check_eq("reset.flags", {30'd0, cout, ovf}, 32'd0);

        do_op("add_basic", 16'h1234, 16'h1111, 1'b0, 1'b0, 0);
        do_op("add_ripple", 16'hFFFF, 16'h0001, 1'b0, 1'b0, 0);
        do_op("add_ovf", 16'h7FFF, 16'h0001, 1'b0, 1'b0, 0);
        do_op("sub_ovf", 16'h8000, 16'h0001, 1'b1, 1'b1, 0);
        do_op("sub_borrow", 16'h0000, 16'h0001, 1'b0, 1'b1, 0);
        do_op("backpressure", 16'hABCD, 16'h1357, 1'b1, 1'b0, 10);
        do_op("after_bp", 16'h0101, 16'h0202, 1'b0, 1'b0, 0);

        // Reset two RUN edges into an op: no partial result must survive
        @(negedge clk);
        a = 16'hFFFF; b = 16'h0001; cin = 1'b0; op = 1'b0; start_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check_eq("midreset.start_ready", 32'(start_ready), 32'd1);
        check_eq("midreset.res_valid", 32'(res_valid), 32'd0);
        check_eq("midreset.sum", 32'(sum), 32'd0);
        check_eq("midreset.cout", 32'(cout), 32'd0);
        do_op("post_reset", 16'h0002, 16'h0003, 1'b0, 1'b0, 0);

        do_op("early_s0", 16'h0003, 16'h0004, 1'b0, 1'b0, 0);
        do_op("early_s1", 16'h000F, 16'h0001, 1'b0, 1'b0, 0);
        do_op("early_cin", 16'h000E, 16'h0001, 1'b1, 1'b0, 0);

        for (int i = 0; i < 150; i++) begin
            sel  = $urandom_range(0, 3);
            mask = (sel == 0) ? 16'h000F : (sel == 1) ? 16'h00FF : 16'hFFFF;
            do_op("rand", W'($urandom) & mask, W'($urandom) & mask, 1'($urandom),
                  1'($urandom), int'($urandom_range(0, 3)));
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
